// File: rtl/mem_stage_dm.sv
// Data memory for the M stage: combinational loads with sign/zero extension,
// clocked byte/half/word stores by read-modify-write merge, and
// misalignment / out-of-range detection that suppresses the access.
module mem_stage_dm #(
  parameter int unsigned DEPTH = 3072,
  parameter int unsigned AW    = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] M_PCAddr,
  input  logic [31:0] M_Addr,
  input  logic [31:0] M_WriteData,
  input  logic        M_MemWrite,
  input  logic        M_MemRead,
  input  logic [2:0]  M_MemOp,
  output logic [31:0] M_ReadData,
  output logic        M_AlignErr,
  output logic        M_RangeErr
);

  typedef enum logic [2:0] {
    OP_W   = 3'd0,
    OP_H   = 3'd1,
    OP_HU  = 3'd2,
    OP_B   = 3'd3,
    OP_BU  = 3'd4
  } mem_op_e;

  logic [31:0]   mem [DEPTH];

  logic [AW-1:0] word_idx;
  logic [1:0]    lane;
  logic          is_half;
  logic          is_byte;
  logic          is_signed;
  logic          access;
  logic          align_bad;
  logic          range_bad;
  logic          err;
  logic [31:0]   old_word;
  logic [31:0]   wr_mask;
  logic [31:0]   wr_data_rep;
  logic [31:0]   merged;
  logic          wr_en;
  logic [15:0]   half_sel;
  logic [7:0]    byte_sel;

  assign word_idx = M_Addr[AW+1:2];
  assign lane     = M_Addr[1:0];
  assign access   = M_MemRead | M_MemWrite;

  // Decode access size; reserved ops fall through as word accesses.
  always_comb begin
    is_half   = 1'b0;
    is_byte   = 1'b0;
    is_signed = 1'b0;
    case (M_MemOp)
      OP_H:    begin is_half = 1'b1; is_signed = 1'b1; end
      OP_HU:   is_half = 1'b1;
      OP_B:    begin is_byte = 1'b1; is_signed = 1'b1; end
      OP_BU:   is_byte = 1'b1;
      default: ;
    endcase
  end

  // Error detection; flags are only reported when an access is requested.
  always_comb begin
    align_bad = 1'b0;
    if (is_byte)      align_bad = 1'b0;
    else if (is_half) align_bad = lane[0];
    else              align_bad = (lane != 2'b00);
    range_bad  = (M_Addr >= 32'(4 * DEPTH));
    err        = align_bad | range_bad;
    M_AlignErr = access & align_bad;
    M_RangeErr = access & range_bad;
  end

  // Old word fetch, guarded so an out-of-range index never touches the array.
  always_comb begin
    old_word = '0;
    if (!range_bad) old_word = mem[word_idx];
  end

  // Load path: lane select then sign/zero extension.
  always_comb begin
    half_sel   = lane[1] ? old_word[31:16] : old_word[15:0];
    case (lane)
      2'd0:    byte_sel = old_word[7:0];
      2'd1:    byte_sel = old_word[15:8];
      2'd2:    byte_sel = old_word[23:16];
      default: byte_sel = old_word[31:24];
    endcase
    M_ReadData = '0;
    if (M_MemRead && !err) begin
      if (is_half)      M_ReadData = {{16{is_signed & half_sel[15]}}, half_sel};
      else if (is_byte) M_ReadData = {{24{is_signed & byte_sel[7]}}, byte_sel};
      else              M_ReadData = old_word;
    end
  end

  // Store path: build lane mask and replicated data, merge over the old word.
  always_comb begin
    if (is_half) begin
      wr_mask     = lane[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
      wr_data_rep = {2{M_WriteData[15:0]}};
    end else if (is_byte) begin
      wr_mask     = 32'h0000_00FF << {lane, 3'b000};
      wr_data_rep = {4{M_WriteData[7:0]}};
    end else begin
      wr_mask     = '1;
      wr_data_rep = M_WriteData;
    end
    merged = (old_word & ~wr_mask) | (wr_data_rep & wr_mask);
    wr_en  = M_MemWrite & ~err;
  end

  // Storage: asynchronous clear of every word, otherwise commit the merged store.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[word_idx] <= merged;
    end
  end

endmodule

// File: tb/tb_mem_stage_dm.sv
// Directed vector bench for mem_stage_dm: one access per cycle with
// hand-computed results, plus reset sequences around stores.
module tb_mem_stage_dm;

  logic        clk;
  logic        reset;
  logic [31:0] M_PCAddr;
  logic [31:0] M_Addr;
  logic [31:0] M_WriteData;
  logic        M_MemWrite;
  logic        M_MemRead;
  logic [2:0]  M_MemOp;
  logic [31:0] M_ReadData;
  logic        M_AlignErr;
  logic        M_RangeErr;

  int unsigned n_pass;
  int unsigned n_total;

  mem_stage_dm #(.DEPTH(3072), .AW(12)) dut (
    .clk         (clk),
    .reset       (reset),
    .M_PCAddr    (M_PCAddr),
    .M_Addr      (M_Addr),
    .M_WriteData (M_WriteData),
    .M_MemWrite  (M_MemWrite),
    .M_MemRead   (M_MemRead),
    .M_MemOp     (M_MemOp),
    .M_ReadData  (M_ReadData),
    .M_AlignErr  (M_AlignErr),
    .M_RangeErr  (M_RangeErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write log for committed stores.
  always @(posedge clk) begin
    if (reset && dut.wr_en)
      $display("%d@%h: *%h <= %h", $time, M_PCAddr, {M_Addr[31:2], 2'b00}, dut.merged);
  end

  typedef struct {
    string       name;
    logic        wr;
    logic        rd;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_al;
    logic        exp_rg;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic drive(input logic wr, input logic rd, input logic [2:0] op,
                       input logic [31:0] addr, input logic [31:0] wdata);
    M_MemWrite  = wr;
    M_MemRead   = rd;
    M_MemOp     = op;
    M_Addr      = addr;
    M_WriteData = wdata;
  endtask

  task automatic check_outs(input string name, input logic [31:0] e_rd,
                            input logic e_al, input logic e_rg);
    check({name, ".rd"}, M_ReadData, e_rd);
    check({name, ".align"}, {31'b0, M_AlignErr}, {31'b0, e_al});
    check({name, ".range"}, {31'b0, M_RangeErr}, {31'b0, e_rg});
  endtask

  task automatic add(input string name, input logic wr, input logic rd, input logic [2:0] op,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rd, input logic exp_al, input logic exp_rg);
    vec_t v;
    v.name = name; v.wr = wr; v.rd = rd; v.op = op; v.addr = addr; v.wdata = wdata;
    v.exp_rd = exp_rd; v.exp_al = exp_al; v.exp_rg = exp_rg;
    vecs.push_back(v);
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    reset = 1'b0;
    M_PCAddr = 32'h0000_3000;
    drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);

    //  name        wr rd op   addr          wdata         exp_rd        al rg
    add("sw0",      1, 0, 3'd0, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 0, 0);
    add("lw0",      0, 1, 3'd0, 32'h0000_0000, 32'h0,         32'h1234_5678, 0, 0);
    add("sb1",      1, 0, 3'd3, 32'h0000_0001, 32'h0000_00AB, 32'h0000_0000, 0, 0);
    add("lw0b",     0, 1, 3'd0, 32'h0000_0000, 32'h0,         32'h1234_AB78, 0, 0);
    add("lb1",      0, 1, 3'd3, 32'h0000_0001, 32'h0,         32'hFFFF_FFAB, 0, 0);
    add("lbu1",     0, 1, 3'd4, 32'h0000_0001, 32'h0,         32'h0000_00AB, 0, 0);
    add("sh6",      1, 0, 3'd1, 32'h0000_0006, 32'h0000_8001, 32'h0000_0000, 0, 0);
    add("lw4",      0, 1, 3'd0, 32'h0000_0004, 32'h0,         32'h8001_0000, 0, 0);
    add("lh6",      0, 1, 3'd1, 32'h0000_0006, 32'h0,         32'hFFFF_8001, 0, 0);
    add("lhu6",     0, 1, 3'd2, 32'h0000_0006, 32'h0,         32'h0000_8001, 0, 0);
    add("lh4",      0, 1, 3'd1, 32'h0000_0004, 32'h0,         32'h0000_0000, 0, 0);
    add("lw2_al",   0, 1, 3'd0, 32'h0000_0002, 32'h0,         32'h0000_0000, 1, 0);
    add("sw5_al",   1, 0, 3'd0, 32'h0000_0005, 32'hFFFF_FFFF, 32'h0000_0000, 1, 0);
    add("lw4_keep", 0, 1, 3'd0, 32'h0000_0004, 32'h0,         32'h8001_0000, 0, 0);
    add("lh5_al",   0, 1, 3'd2, 32'h0000_0005, 32'h0,         32'h0000_0000, 1, 0);
    add("sw3000",   1, 0, 3'd0, 32'h0000_3000, 32'h0000_0001, 32'h0000_0000, 0, 1);
    add("swtop",    1, 0, 3'd0, 32'h0000_2FFC, 32'hDEAD_BEEF, 32'h0000_0000, 0, 0);
    add("lwtop",    0, 1, 3'd0, 32'h0000_2FFC, 32'h0,         32'hDEAD_BEEF, 0, 0);
    add("lw3000",   0, 1, 3'd0, 32'h0000_3000, 32'h0,         32'h0000_0000, 0, 1);
    add("lbu2fff",  0, 1, 3'd4, 32'h0000_2FFF, 32'h0,         32'h0000_00DE, 0, 0);
    add("lb2ffe",   0, 1, 3'd3, 32'h0000_2FFE, 32'h0,         32'hFFFF_FFAD, 0, 0);
    add("lhu2ffe",  0, 1, 3'd2, 32'h0000_2FFE, 32'h0,         32'h0000_DEAD, 0, 0);
    add("lw_rsv_al",0, 1, 3'd5, 32'h0000_0001, 32'h0,         32'h0000_0000, 1, 0);
    add("lw_rsv",   0, 1, 3'd7, 32'h0000_2FFC, 32'h0,         32'hDEAD_BEEF, 0, 0);
    add("idle",     0, 0, 3'd0, 32'h0000_3002, 32'h0,         32'h0000_0000, 0, 0);
    add("rdnoen",   0, 0, 3'd0, 32'h0000_0000, 32'h0,         32'h0000_0000, 0, 0);
    add("lwsw8",    1, 1, 3'd0, 32'h0000_0008, 32'h0000_0055, 32'h0000_0000, 0, 0);
    add("lw8",      0, 1, 3'd0, 32'h0000_0008, 32'h0,         32'h0000_0055, 0, 0);

    // During reset: reads are zero, flags still follow the inputs.
    @(negedge clk);
    drive(1'b0, 1'b1, 3'd0, 32'h0000_0000, 32'h0);
    #1 check_outs("rst_lw0", 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b1, 3'd0, 32'h0000_0002, 32'h0);
    #1 check_outs("rst_lw2", 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].wr, vecs[i].rd, vecs[i].op, vecs[i].addr, vecs[i].wdata);
      #1 check_outs(vecs[i].name, vecs[i].exp_rd, vecs[i].exp_al, vecs[i].exp_rg);
    end

    // Store with reset asserted before the edge and held across it: store is lost.
    @(negedge clk);
    drive(1'b1, 1'b0, 3'd0, 32'h0000_0010, 32'h0000_0077);
    #1 reset = 1'b0;
    @(negedge clk);
    drive(1'b0, 1'b1, 3'd0, 32'h0000_0008, 32'h0);
    #1 check_outs("midrst_lw8", 32'h0, 1'b0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    drive(1'b0, 1'b1, 3'd0, 32'h0000_0010, 32'h0);
    #1 check_outs("post_lw10", 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b1, 3'd0, 32'h0000_0000, 32'h0);
    #1 check_outs("post_lw0", 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b1, 3'd0, 32'h0000_2FFC, 32'h0);
    #1 check_outs("post_lwtop", 32'h0, 1'b0, 1'b0);

    // Memory still writable after the reset pulse.
    @(negedge clk);
    drive(1'b1, 1'b0, 3'd4, 32'h0000_0013, 32'h0000_00C3);
    @(negedge clk);
    drive(1'b0, 1'b1, 3'd0, 32'h0000_0010, 32'h0);
    #1 check_outs("post_sb13", 32'hC300_0000, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
